// File: rtl/bp_pkg.sv
// bp_pkg: shared defaults, counter saturation step and index hash for the branch history table
package bp_pkg;
  localparam int PC_BITS_D = 32;
  localparam int INDEX_BITS_D = 4;
  localparam int CTR_BITS_D = 2;
  localparam int GHR_BITS_D = 4;
  localparam int HASH_W = 16;
  function automatic logic [3:0] sat_step(input logic [3:0] c, input logic taken, input int bits);
    logic [3:0] top;
    top = 4'((1 << bits) - 1);
    return taken ? (c == top ? c : c + 4'd1) : (c == 4'd0 ? c : c - 4'd1);
  endfunction
  function automatic logic [HASH_W-1:0] idx_hash(input logic [63:0] pc, input logic [HASH_W-1:0] ghr);
    return pc[HASH_W+1:2] ^ ghr;
  endfunction
endpackage

// File: rtl/bht_predictor_if.sv
// bht_predictor_if: fetch request, prediction response and execute resolution signals
interface bht_predictor_if #(
  parameter int PC_BITS = 32,
  parameter int INDEX_BITS = 4
);
  logic req_valid;
  logic [PC_BITS-1:0] req_pc;
  logic pred_valid;
  logic pred_taken;
  logic [INDEX_BITS-1:0] pred_index;
  logic upd_valid;
  logic [INDEX_BITS-1:0] upd_index;
  logic upd_taken;
  logic hist_clear;
  modport master (
    output req_valid, req_pc, upd_valid, upd_index, upd_taken, hist_clear,
    input pred_valid, pred_taken, pred_index
  );
  modport slave (
    input req_valid, req_pc, upd_valid, upd_index, upd_taken, hist_clear,
    output pred_valid, pred_taken, pred_index
  );
endinterface

// File: rtl/bht_predictor_sat_ctr.sv
// sat_ctr: one saturating up/down direction counter of the table
module sat_ctr
  import bp_pkg::*;
#(
  parameter int CTR_BITS = 2,
  parameter logic [CTR_BITS-1:0] INIT = '1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic taken,
  output logic [CTR_BITS-1:0] count,
  output logic msb
);
  // count toward taken/not-taken, clamping at both ends
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= INIT;
    else if (en) count <= CTR_BITS'(sat_step(4'(count), taken, CTR_BITS));
  assign msb = count[CTR_BITS-1];
endmodule

// File: rtl/bht_predictor.sv
// bht_predictor: bimodal/gshare branch history table with registered one-cycle prediction
module bht_predictor
  import bp_pkg::*;
#(
  parameter int PC_BITS = PC_BITS_D,
  parameter int INDEX_BITS = INDEX_BITS_D,
  parameter int CTR_BITS = CTR_BITS_D,
  parameter int GHR_BITS = GHR_BITS_D,
  parameter int INIT_CTR = (1 << CTR_BITS) - 1
) (
  input logic clk,
  input logic rst,
  bht_predictor_if.slave bus
);
  localparam int DEPTH = 1 << INDEX_BITS;
  localparam int GW = GHR_BITS > 0 ? GHR_BITS : 1;
  logic [GW-1:0] ghr;
  logic [INDEX_BITS-1:0] idx;
  logic [DEPTH-1:0] msb;
  assign idx = INDEX_BITS'(idx_hash(64'(bus.req_pc), HASH_W'(ghr)));
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    sat_ctr #(.CTR_BITS(CTR_BITS), .INIT(CTR_BITS'(INIT_CTR))) u_ctr (
      .clk(clk),
      .rst(rst),
      .en(bus.upd_valid && bus.upd_index == INDEX_BITS'(i)),
      .taken(bus.upd_taken),
      .count(),
      .msb(msb[i])
    );
  end
  if (GHR_BITS > 0) begin : g_ghr
    // resolved outcomes shift in non-speculatively; clear wins over a shift
    always_ff @(posedge clk or posedge rst)
      if (rst) ghr <= '0;
      else if (bus.hist_clear) ghr <= '0;
      else if (bus.upd_valid) ghr <= GW'({ghr, bus.upd_taken});
  end else begin : g_nohist
    assign ghr = '0;
  end
  // prediction reads the pre-update counter and pre-update history
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.pred_valid <= 1'b0;
      bus.pred_taken <= 1'b0;
      bus.pred_index <= '0;
    end else begin
      bus.pred_valid <= bus.req_valid;
      if (bus.req_valid) begin
        bus.pred_taken <= msb[idx];
        bus.pred_index <= idx;
      end
    end
endmodule

// File: tb/tb_bht_predictor.sv
// tb_bht_predictor: bimodal and gshare predictors checked against a table-level reference model
module tb_bht_predictor;
  logic clk = 0;
  logic rst = 1;
  int tests = 0;
  int fails = 0;
  int m0[16];
  int m4[16];
  int g4;
  int ei0, ei4;
  bit ev0, et0, ev4, et4;

  always #5 clk = ~clk;

  bht_predictor_if #(.PC_BITS(32), .INDEX_BITS(4)) b0 ();
  bht_predictor_if #(.PC_BITS(32), .INDEX_BITS(4)) b4 ();

  bht_predictor #(.GHR_BITS(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  bht_predictor #(.GHR_BITS(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit rv, input int unsigned pc, input bit uv, input int ui, input bit ut, input bit hc);
    b0.req_valid = rv; b0.req_pc = pc; b0.upd_valid = uv; b0.upd_index = 4'(ui); b0.upd_taken = ut; b0.hist_clear = hc;
    b4.req_valid = rv; b4.req_pc = pc; b4.upd_valid = uv; b4.upd_index = 4'(ui); b4.upd_taken = ut; b4.hist_clear = hc;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m0[i] = 3;
      m4[i] = 3;
    end
    g4 = 0; ei0 = 0; ei4 = 0;
    ev0 = 0; et0 = 0; ev4 = 0; et4 = 0;
  endtask

  task automatic check_all();
    chk("dut0.pred_valid", 32'(b0.pred_valid), 32'(ev0));
    chk("dut0.pred_taken", 32'(b0.pred_taken), 32'(et0));
    chk("dut0.pred_index", 32'(b0.pred_index), 32'(ei0));
    chk("dut4.pred_valid", 32'(b4.pred_valid), 32'(ev4));
    chk("dut4.pred_taken", 32'(b4.pred_taken), 32'(et4));
    chk("dut4.pred_index", 32'(b4.pred_index), 32'(ei4));
  endtask

  task automatic step(input bit rv, input int unsigned pc, input bit uv, input int ui, input bit ut, input bit hc);
    drive(rv, pc, uv, ui, ut, hc);
    @(posedge clk);
    #1;
    ev0 = rv;
    ev4 = rv;
    if (rv) begin
      ei0 = int'((pc >> 2) % 16);
      et0 = m0[ei0] >= 2;
      ei4 = int'(((pc >> 2) ^ g4) % 16);
      et4 = m4[ei4] >= 2;
    end
    if (uv) begin
      m0[ui] = ut ? (m0[ui] == 3 ? 3 : m0[ui] + 1) : (m0[ui] == 0 ? 0 : m0[ui] - 1);
      m4[ui] = ut ? (m4[ui] == 3 ? 3 : m4[ui] + 1) : (m4[ui] == 0 ? 0 : m4[ui] - 1);
      g4 = (g4 * 2 + int'(ut)) % 16;
    end
    if (hc) g4 = 0;
    check_all();
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 0;
    // bimodal lookup of PC 0x14 lands on entry 5, initially strongly taken
    step(1, 32'h14, 0, 0, 0, 0);
    chk("first_pred_index", 32'(b0.pred_index), 5);
    chk("first_pred_taken", 32'(b0.pred_taken), 1);
    // walk entry 5 down and back up across both saturation limits
    step(0, 0, 1, 5, 0, 0);
    step(0, 0, 1, 5, 0, 0);
    step(1, 32'h14, 0, 0, 0, 0);
    chk("ctr1_not_taken", 32'(b0.pred_taken), 0);
    repeat (3) step(0, 0, 1, 5, 0, 0);
    step(0, 0, 1, 5, 1, 0);
    step(1, 32'h14, 0, 0, 0, 0);
    chk("no_wrap_below_0", 32'(b0.pred_taken), 0);
    step(0, 0, 1, 5, 1, 0);
    step(1, 32'h14, 0, 0, 0, 0);
    chk("ctr2_taken", 32'(b0.pred_taken), 1);
    repeat (4) step(0, 0, 1, 5, 1, 0);
    step(0, 0, 1, 5, 0, 0);
    step(1, 32'h14, 0, 0, 0, 0);
    chk("no_wrap_above_3", 32'(b0.pred_taken), 1);
    // same-cycle request and update on entry 5 sees the old counter
    step(1, 32'h14, 1, 5, 0, 0);
    chk("read_before_write", 32'(b0.pred_taken), 1);
    step(1, 32'h14, 0, 0, 0, 0);
    chk("after_write", 32'(b0.pred_taken), 0);
    // build history 1101 on the gshare predictor
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 1, 0);
    step(0, 0, 1, 0, 1, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 1, 0);
    step(1, 32'h14, 0, 0, 0, 0);
    chk("gshare_index", 32'(b4.pred_index), 8);
    chk("gshare_taken", 32'(b4.pred_taken), 1);
    chk("bimodal_index", 32'(b0.pred_index), 5);
    step(0, 0, 0, 0, 0, 1);
    step(1, 32'h14, 0, 0, 0, 0);
    chk("cleared_index", 32'(b4.pred_index), 5);
    // drive entry 5 to zero, then reset with a prediction outstanding
    step(0, 0, 1, 5, 0, 0);
    step(1, 32'h14, 0, 0, 0, 0);
    chk("ctr0_pred", 32'(b0.pred_taken), 0);
    drive(1, 32'h14, 0, 0, 0, 0);
    #2;
    rst = 1;
    model_reset();
    #1;
    chk("rst_drops_valid", 32'(b0.pred_valid), 0);
    check_all();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    rst = 0;
    @(posedge clk);
    #1;
    chk("no_pulse_after_rst", 32'(b0.pred_valid), 0);
    check_all();
    step(1, 32'h14, 0, 0, 0, 0);
    chk("post_rst_taken", 32'(b0.pred_taken), 1);
    // back-to-back requests, one pulse per cycle in order
    for (int i = 0; i < 8; i++) begin
      step(1, 32'(i * 4), 0, 0, 0, 0);
      chk("b2b_valid", 32'(b0.pred_valid), 1);
      chk("b2b_index", 32'(b0.pred_index), 32'(i));
    end
    // randomized traffic with overlapping requests, updates and clears
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bht_predictor.md
Name: bht_predictor

Overview:
- Parametrised branch history table: 2^INDEX_BITS saturating counters, each CTR_BITS wide, replacing the single 2-bit counter predictor.
- Supports bimodal indexing (PC only) and gshare indexing (PC XOR global history register).
- Prediction and resolution may occur in the same cycle.
- Sits beside fetch: fetch issues prediction requests; the execute stage returns resolved outcomes.

Parameters:
- PC_BITS, 32, width of the request PC.
- INDEX_BITS, 4, table index width; table depth = 2^INDEX_BITS.
- CTR_BITS, 2, counter width; legal range 1..4.
- GHR_BITS, 4, global history length; 0 = pure bimodal; must be <= INDEX_BITS.
- INIT_CTR, 2^CTR_BITS-1, reset value of every counter (strongly taken).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  prediction request this cycle.
- req_pc  in  PC_BITS  fetch PC; bits [1:0] ignored.
- pred_valid  out  1  prediction valid, one-cycle pulse.
- pred_taken  out  1  predicted direction.
- pred_index  out  INDEX_BITS  table index used; fetch returns it on update.
- upd_valid  in  1  resolved branch outcome this cycle.
- upd_index  in  INDEX_BITS  index previously returned on pred_index.
- upd_taken  in  1  actual direction.
- hist_clear  in  1  synchronous clear of the GHR.

Behaviour:
- Reset (async, immediate on rst=1):
  - all counters = INIT_CTR; GHR = 0.
  - pred_valid = 0, pred_taken = 0, pred_index = 0.
  - Reset asserted mid-operation discards any in-flight prediction; no pulse follows deassertion.
- Index:
  - idx = req_pc[INDEX_BITS+1:2] XOR zero-extended GHR.
  - GHR_BITS = 0 gives idx = PC bits only.
- Prediction latency is 1 cycle. On a req_valid edge, the next cycle presents:
  - pred_valid = 1
  - pred_taken = MSB of counter[idx]
  - pred_index = idx
- With req_valid = 0: pred_valid = 0, and pred_taken/pred_index hold their last values.
- No backpressure; a request is accepted every cycle.
- Update, on an upd_valid edge:
  - upd_taken = 1: counter[upd_index] increments, saturating at 2^CTR_BITS-1.
  - upd_taken = 0: counter decrements, saturating at 0.
  - No wrap-around in either direction.
- GHR update: when upd_valid, GHR <= {GHR[GHR_BITS-2:0], upd_taken} (non-speculative; oldest bit dropped).
- hist_clear:
  - sets GHR = 0 on that edge and has priority over a simultaneous GHR shift.
  - does not affect counters.
- Simultaneous request and update:
  - Both are processed in the same cycle.
  - On the same index, the prediction uses the pre-update counter value (read-before-write).
  - The GHR used for indexing is the pre-update value.
- Only the single addressed entry changes per update. Counters are a flop array (no RAM), so reset is possible.

Decomposition:
- Package bp_pkg holds:
  - default parameter constants;
  - the counter-increment/decrement saturation function;
  - the index-hash function (PC slice XOR GHR).
- One sub-module, sat_ctr (CTR_BITS param; inputs en, taken; output count, msb), instantiated per entry via generate.
- GHR and the output register stay in the top level.

Test Plan:
- Reset then req_pc=0x14 (GHR_BITS=0) -> next cycle pred_valid=1, pred_index=5, pred_taken=1.
- Two updates idx 5 not-taken, then req 0x14 -> counter 1, pred_taken=0. Three more not-taken then one taken -> counter 1, pred 0. Second taken -> counter 2, pred 1. No wrap below 0 or above 3.
- Counter at 2; req 0x14 and upd idx 5 not-taken in the same cycle -> pred_taken=1 (old value). Following req -> pred_taken=0.
- GHR_BITS=4: updates on idx 0 with taken, taken, not-taken, taken -> GHR=0xD.
  - req 0x14 -> pred_index=8, pred_taken=1.
  - hist_clear, then req 0x14 -> pred_index=5.
- rst pulsed while counter[5]=0 and a request is in flight -> pred_valid drops immediately, no pulse after release. Next req 0x14 -> pred_taken=1.
- Back-to-back req_valid for 8 cycles with PCs 0x0..0x1C -> 8 consecutive pred_valid pulses, pred_index 0..7 in order.
